// File: rtl/seven_segment_mux.sv
// -----------------------------------------------------------------------------
// seven_segment_mux
//
// Converts a captured unsigned binary value to BCD with a serial double-dabble
// engine (one shift step per clock). It then time-multiplexes the resulting
// digits onto a common seven-segment bus.
//
// Parameters
//   DIGITS   : number of multiplexed digits (1..5)
//   VAL_W    : width of the binary input value (4..17)
//   SCAN_DIV : clk cycles each digit stays enabled (>= 2)
//
// Ports
//   clk      : single rising-edge clock
//   rst_n    : asynchronous active-low reset
//   load     : one-cycle request to capture value (ignored while busy)
//   value    : unsigned binary number to display
//   blank_lz : blank leading zeros; sampled live at every digit switch
//   busy     : high while a conversion is in flight (SHIFT and COMMIT)
//   done     : one-cycle pulse after new digits are committed
//   overflow : committed value does not fit in DIGITS decimal digits
//   seg      : active-high segments, bit6 = a ... bit0 = g
//   an       : one-hot active-high digit enable, bit0 = least-significant digit
// -----------------------------------------------------------------------------
module seven_segment_mux #(
    parameter int DIGITS   = 4,
    parameter int VAL_W    = 14,
    parameter int SCAN_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [VAL_W-1:0]  value,
    input  logic              blank_lz,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int AW = 4 * DIGITS;                        // BCD accumulator width
    localparam int CW = $clog2(VAL_W);                     // step counter 0..VAL_W-1
    localparam int PW = $clog2(SCAN_DIV);                  // prescaler width
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1; // digit index width

    function automatic int unsigned pow10(input int n);
        int unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam int unsigned   MAX_VAL    = pow10(DIGITS) - 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(VAL_W - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    // Conversion engine state
    state_t           state_reg;
    logic [VAL_W-1:0] sr_reg;
    logic [AW-1:0]    acc_reg;
    logic [AW-1:0]    disp_reg;
    logic [CW-1:0]    cnt_reg;
    logic             ovf_pend_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             overflow_reg;

    // Scan state
    logic [PW-1:0]     presc_reg;
    logic [IW-1:0]     idx_reg;
    logic [IW-1:0]     idx_next;
    logic [DIGITS-1:0] an_reg;
    logic [6:0]        seg_reg;

    logic          value_ovf;
    logic [AW-1:0] acc_adj;
    logic [6:0]    digit_seg [DIGITS];

    assign value_ovf = (32'(value) > MAX_VAL);

    // Per-digit logic: the double-dabble "add 3 if >= 5" correction on the
    // accumulator, and the segment pattern each committed digit would show.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        localparam bit CAN_BLANK = (gi != 0);   // digit 0 always shows something
        logic [3:0] acc_nib;
        logic [3:0] disp_nib;
        logic       lead_zero;

        assign acc_nib  = acc_reg[4*gi +: 4];
        assign acc_adj[4*gi +: 4] = (acc_nib >= 4'd5) ? acc_nib + 4'd3 : acc_nib;

        assign disp_nib = disp_reg[4*gi +: 4];
        // This digit and everything more significant are zero.
        assign lead_zero = (disp_reg[AW-1:4*gi] == '0);

        // Overflow dash wins over both the digit data and blanking.
        assign digit_seg[gi] = overflow_reg                         ? 7'b0000001 :
                               (blank_lz && lead_zero && CAN_BLANK) ? 7'b0000000 :
                                                                      seg7(disp_nib);
    end

    // Conversion FSM. The display register is written only in COMMIT, so the
    // scan never sees a half-converted accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            sr_reg       <= '0;
            acc_reg      <= '0;
            disp_reg     <= '0;
            cnt_reg      <= '0;
            ovf_pend_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        sr_reg       <= value;
                        acc_reg      <= '0;
                        cnt_reg      <= '0;
                        ovf_pend_reg <= value_ovf;
                        busy_reg     <= 1'b1;
                        state_reg    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Corrected accumulator shifted left, pulling in the binary
                    // MSB. The bit shifted out of the top is only non-zero on
                    // overflow, which is flagged separately.
                    acc_reg <= AW'({acc_adj, sr_reg[VAL_W-1]});
                    sr_reg  <= sr_reg << 1;
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= COMMIT;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                COMMIT: begin
                    disp_reg     <= acc_reg;
                    overflow_reg <= ovf_pend_reg;
                    done_reg     <= 1'b1;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;

    // Free-running scan. an and seg are reloaded together on the prescaler
    // wrap, so the segment bus never carries one digit's pattern while the
    // neighbouring digit is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
            idx_reg   <= '0;
            an_reg    <= DIGITS'(1);
            seg_reg   <= 7'b1111110;
        end else begin
            if (presc_reg == PRESC_LAST) begin
                presc_reg <= '0;
                idx_reg   <= idx_next;
                an_reg    <= DIGITS'(1) << idx_next;
                seg_reg   <= digit_seg[idx_next];
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign overflow = overflow_reg;
    assign seg      = seg_reg;
    assign an       = an_reg;

endmodule

// File: tb/tb_seven_segment_mux.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_mux
//
// Directed and randomized checks of seven_segment_mux with DIGITS=4, VAL_W=14,
// SCAN_DIV=4. Expected digits come from decimal arithmetic on the loaded value.
// Expected digit enables come from the number of clock edges since reset
// release.
// -----------------------------------------------------------------------------
module tb_seven_segment_mux;

    localparam int DIGITS   = 4;
    localparam int VAL_W    = 14;
    localparam int SCAN_DIV = 4;

    logic              clk;
    logic              rst_n;
    logic              load;
    logic [VAL_W-1:0]  value;
    logic              blank_lz;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;   // rising edges since the last reset release
    int dones  = 0;
    int rv;
    int rb;

    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011};

    seven_segment_mux #(
        .DIGITS   (DIGITS),
        .VAL_W    (VAL_W),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .seg      (seg),
        .an       (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Expected segment pattern of decimal digit d for a committed value v.
    function automatic logic [6:0] exp_seg(input int v, input int blank, input int d);
        int p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        if (v > 9999) return 7'b0000001;
        if (blank != 0 && d > 0 && v < p) return 7'b0000000;
        return seg_tab[(v / p) % 10];
    endfunction

    // Load v; optionally retry a load of v2 at edge N+second_at while busy.
    task automatic run_load(input int v, input int blank, input int second_at, input int v2);
        int k;
        blank_lz = (blank != 0);
        value    = VAL_W'(v);
        load     = 1'b1;
        tick();
        load     = 1'b0;
        value    = VAL_W'($urandom);
        $display("load value=%0d blank_lz=%0d", v, blank);
        chk("busy_rise", busy, 1);
        k = 0;
        while (busy === 1'b1 && k < 40) begin
            if (k + 1 == second_at) begin
                value = VAL_W'(v2);
                load  = 1'b1;
            end
            tick();
            load = 1'b0;
            k++;
        end
        chk("busy_cycles", k, VAL_W + 1);
        chk("done_pulse", done, 1);
        chk("overflow", overflow, (v > 9999) ? 1 : 0);
        tick();
        chk("done_clear", done, 0);
    endtask

    // Wait for a digit switch after now, then check one full scan.
    task automatic check_scan(input int v, input int blank);
        int guard;
        int d;
        guard = 0;
        do begin
            tick();
            guard++;
        end while ((cyc % SCAN_DIV) != 0 && guard < 2 * SCAN_DIV);
        chk("scan_sync", ((cyc % SCAN_DIV) == 0) ? 1 : 0, 1);
        for (int s = 0; s < DIGITS; s++) begin
            d = (cyc / SCAN_DIV) % DIGITS;
            chk("scan_an", an, 32'(1) << d);
            chk($sformatf("seg_digit%0d_v%0d", d, v), seg, exp_seg(v, blank, d));
            repeat (SCAN_DIV) tick();
        end
        $display("scan value=%0d blank_lz=%0d checked", v, blank);
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = '0;
        blank_lz = 1'b0;

        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_an", an, 1);
        chk("rst_seg", seg, 7'b1111110);
        #10;
        rst_n = 1'b1;
        cyc   = 0;

        // First cycle after release accepts a load
        run_load(1234, 0, -1, 0);
        check_scan(1234, 0);

        // Leading-zero blanking, then live toggle of blank_lz
        run_load(7, 1, -1, 0);
        check_scan(7, 1);
        blank_lz = 1'b0;
        check_scan(7, 0);

        // Overflow shows dashes regardless of blanking, then clears
        run_load(12000, 1, -1, 0);
        check_scan(12000, 1);
        run_load(9999, 0, -1, 0);
        check_scan(9999, 0);

        // Load while busy is ignored
        dones = 0;
        run_load(42, 0, 3, 99);
        check_scan(42, 0);

        // Zero value
        run_load(0, 1, -1, 0);
        check_scan(0, 1);
        blank_lz = 1'b0;
        check_scan(0, 0);

        // Randomized loads, including random overflow and blanking
        for (int i = 0; i < 8; i++) begin
            rv = int'($urandom_range(0, 16383));
            rb = int'($urandom_range(0, 1));
            run_load(rv, rb, -1, 0);
            check_scan(rv, rb);
        end

        // Reset in the middle of a conversion
        blank_lz = 1'b0;
        value    = VAL_W'(5555);
        load     = 1'b1;
        tick();
        load     = 1'b0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        $display("reset asserted mid-conversion");
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_an", an, 1);
        chk("midrst_seg", seg, 7'b1111110);
        repeat (2) @(posedge clk);
        #4;
        rst_n = 1'b1;
        cyc   = 0;

        // Free run: an one-hot, each digit held SCAN_DIV cycles, no done
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) dones++;
            chk("free_an", an, 32'(1) << ((cyc / SCAN_DIV) % DIGITS));
            chk("free_onehot", $onehot(an) ? 1 : 0, 1);
            if (i == 0) chk("post_rst_seg", seg, 7'b1111110);
        end
        chk("no_done_after_abort", dones, 0);
        chk("post_rst_busy", busy, 0);
        check_scan(0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
